my_top: RTL and testbench



---
 rtl/mux2_sel.sv | 34 +++
 rtl/my_top.sv | 51 +++++
 tb/tb_my_top.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mux2_sel.sv
// 2:1 data selector with the implementation style chosen at elaboration.
// Both styles give identical results, including when sel is unknown.
module mux2_sel #(
  parameter int USE_CASE = 0,
  parameter int WIDTH    = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  localparam int UseAssign = 0;
  localparam int UseCase   = 1;

  generate
    if (USE_CASE == UseCase) begin : g_case
      always_comb begin
        case (sel)
          1'b0:    y = a;
          1'b1:    y = b;
          // NOTE: an unknown sel keeps the bits where a and b agree and makes
          // the rest X, matching the ?: form so both styles stay equivalent.
          default: y = (a & b) | ((a ^ b) & {WIDTH{1'bx}});
        endcase
      end
    end else if (USE_CASE == UseAssign) begin : g_assign
      assign y = sel ? b : a;
    end else begin : g_illegal
      $error("mux2_sel: USE_CASE must be 0 or 1, got %0d", USE_CASE);
    end
  endgenerate

endmodule

// File: rtl/my_top.sv
// Parameterised 2:1 selector with an optional output register stage that
// has a synchronous active-low clear.
module my_top #(
  parameter int USE_CASE = 0,
  parameter int WIDTH    = 1,
  parameter int REG_OUT  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] sel_y;

  mux2_sel #(
    .USE_CASE (USE_CASE),
    .WIDTH    (WIDTH)
  ) u_mux2_sel (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (sel_y)
  );

  generate
    if (REG_OUT == 1) begin : g_reg
      logic [WIDTH-1:0] out_d;
      logic [WIDTH-1:0] out_q;

      always_comb begin
        out_d = rst_n ? sel_y : '0;
      end

      // NOTE: reset is folded into out_d, so it only takes effect on a clock
      // edge; the register itself has no asynchronous clear.
      always_ff @(posedge clk) begin
        out_q <= out_d;
      end

      assign out = out_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = &{1'b0, clk, rst_n};
      assign out = sel_y;
    end
  endgenerate

endmodule

// File: tb/tb_my_top.sv
// Directed bench for my_top: truth table, wide side-by-side sweep,
// unknown select and the registered path with mid-stream reset.
module tb_my_top;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a1, b1, sel1;
  logic [7:0] a8, b8;
  logic       sel8;
  logic       ra, rb, rsel;

  logic       out_c0, out_c1;
  logic [7:0] out_w0, out_w1;
  logic       out_r;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  my_top #(.USE_CASE(0), .WIDTH(1), .REG_OUT(0)) u_c0 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .out(out_c0));
  my_top #(.USE_CASE(1), .WIDTH(1), .REG_OUT(0)) u_c1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .out(out_c1));
  my_top #(.USE_CASE(0), .WIDTH(8), .REG_OUT(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .out(out_w0));
  my_top #(.USE_CASE(1), .WIDTH(8), .REG_OUT(0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .sel(sel8), .out(out_w1));
  my_top #(.USE_CASE(1), .WIDTH(1), .REG_OUT(1)) u_r (
    .clk(clk), .rst_n(rst_n), .a(ra), .b(rb), .sel(rsel), .out(out_r));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       x_probe;
    logic [2:0] v;
    logic [7:0] exp8;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; sel8 = 1'b0;
    ra = 1'b1; rb = 1'b0; rsel = 1'b1;

    // Exhaustive truth table, both styles.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      a1 = v[2]; b1 = v[1]; sel1 = v[0];
      #1;
      check($sformatf("tt_assign_%0d", i), {7'd0, out_c0}, {7'd0, v[0] ? v[1] : v[2]});
      check($sformatf("tt_case_%0d", i),   {7'd0, out_c1}, {7'd0, v[0] ? v[1] : v[2]});
    end

    // Directed wide vectors.
    a8 = 8'hA5; b8 = 8'h3C; sel8 = 1'b1; #1;
    check("w_a5_3c_s1_assign", out_w0, 8'h3C);
    check("w_a5_3c_s1_case",   out_w1, 8'h3C);
    sel8 = 1'b0; #1;
    check("w_a5_3c_s0_assign", out_w0, 8'hA5);
    check("w_a5_3c_s0_case",   out_w1, 8'hA5);

    // Pseudo-random sweep, both styles against the bench model.
    for (int i = 0; i < 1000; i++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      sel8 = 1'($urandom);
      exp8 = sel8 ? b8 : a8;
      #1;
      check($sformatf("rnd_assign_%0d", i), out_w0, exp8);
      check($sformatf("rnd_case_%0d", i),   out_w1, exp8);
    end

    // Unknown select; only meaningful on a four-state simulator.
    x_probe = 1'bx;
    if ($isunknown(x_probe)) begin
      a8 = 8'hF0; b8 = 8'hFF; sel8 = 1'bx; #1;
      check("xsel_assign", out_w0, 8'b1111_xxxx);
      check("xsel_case",   out_w1, 8'b1111_xxxx);
    end else begin
      $display("note: two-state simulator, unknown-select vectors skipped");
    end

    // Registered path: hold reset for two edges.
    @(posedge clk); @(posedge clk); #1;
    check("reg_reset_hold", {7'd0, out_r}, 8'd0);

    @(negedge clk);
    rst_n = 1'b1; ra = 1'b1; rb = 1'b0; rsel = 1'b1;
    @(posedge clk); #1;
    check("reg_first_sel_b", {7'd0, out_r}, 8'd0);

    @(negedge clk);
    rsel = 1'b0; #1;
    check("reg_no_comb_path", {7'd0, out_r}, 8'd0);
    @(posedge clk); #1;
    check("reg_sel_a", {7'd0, out_r}, 8'd1);

    // Reset mid-stream: seen only at the next rising edge.
    @(negedge clk);
    rst_n = 1'b0; #1;
    check("reg_rst_before_edge", {7'd0, out_r}, 8'd1);
    @(posedge clk); #1;
    check("reg_rst_at_edge", {7'd0, out_r}, 8'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reg_restore", {7'd0, out_r}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
